// File: rtl/rv32i_pkg.sv
// RV32I encoder types, funct constants and the shared field-to-word encoder.
// Latency: n/a (pure declarations and a combinational function).
// Backpressure: n/a.
package rv32i_pkg;

   localparam int ADW = 5;
   localparam int DPW = 32;

   typedef enum logic [6:0] {
      R_TYPE      = 7'b0110011,
      I_TYPE_ALU  = 7'b0010011,
      I_TYPE_LOAD = 7'b0000011,
      S_TYPE      = 7'b0100011,
      B_TYPE      = 7'b1100011
   } instr_type_t;

   typedef enum logic [3:0] {
      ADD_OP = 4'd0,
      SUB_OP = 4'd1,
      AND_OP = 4'd2,
      OR_OP  = 4'd3,
      XOR_OP = 4'd4,
      SLL_OP = 4'd5,
      SRL_OP = 4'd6,
      SRA_OP = 4'd7,
      BEQ_OP = 4'd8
   } alu_op_t;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SUB = 3'b000;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRL = 3'b101;
   localparam logic [2:0] F3_SRA = 3'b101;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic            illegal;
      logic [DPW-1:0]  word;
   } enc_t;

   // Field-level request -> {illegal, machine word}; word is don't-care when illegal.
   function automatic enc_t encode_instr(input logic [6:0]     i_type,
                                         input logic [3:0]     i_op,
                                         input logic [ADW-1:0] i_rd,
                                         input logic [ADW-1:0] i_rs1,
                                         input logic [ADW-1:0] i_rs2,
                                         input logic [12:0]    i_imm);
      enc_t       r;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       alu_ok;
      logic       is_shift;
      r        = '0;
      f3       = F3_ADD;
      f7       = F7_BASE;
      alu_ok   = 1'b1;
      is_shift = 1'b0;
      case (i_op)
         ADD_OP:  f3 = F3_ADD;
         SUB_OP:  begin f3 = F3_SUB; f7 = F7_ALT; end
         AND_OP:  f3 = F3_AND;
         OR_OP:   f3 = F3_OR;
         XOR_OP:  f3 = F3_XOR;
         SLL_OP:  begin f3 = F3_SLL; is_shift = 1'b1; end
         SRL_OP:  begin f3 = F3_SRL; is_shift = 1'b1; end
         SRA_OP:  begin f3 = F3_SRA; f7 = F7_ALT; is_shift = 1'b1; end
         default: alu_ok = 1'b0;   // BEQ and undefined ops have no ALU encoding
      endcase
      case (i_type)
         R_TYPE: begin
            r.illegal = !alu_ok;
            r.word    = {f7, i_rs2, i_rs1, f3, i_rd, i_type};
         end
         I_TYPE_ALU: begin
            r.illegal = !alu_ok || (i_op == SUB_OP);
            if (is_shift)
               r.word = {f7, i_imm[4:0], i_rs1, f3, i_rd, i_type};
            else
               r.word = {i_imm[11:0], i_rs1, f3, i_rd, i_type};
         end
         I_TYPE_LOAD: begin
            r.word = {i_imm[11:0], i_rs1, F3_LW, i_rd, i_type};
         end
         S_TYPE: begin
            r.illegal = (i_op == BEQ_OP);
            r.word    = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], i_type};
         end
         B_TYPE: begin
            r.illegal = (i_op != BEQ_OP) || i_imm[0];
            r.word    = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                         i_imm[4:1], i_imm[11], i_type};
         end
         default: r.illegal = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Generic synchronous FIFO with clear; head word shown combinationally on dout.
// Latency: a pushed word is visible at dout the cycle after push into an empty FIFO.
// Backpressure: push ignored when full, pop ignored when empty; clear wins over both.
module rv32i_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wp;
   logic [AW:0]  r_rp;

   // Pointer and storage update; storage is zeroed on reset so dout reads 0 out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp <= '0;
         r_rp <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (clear) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (push && !full) begin
            r_mem[r_wp[AW-1:0]] <= din;
            r_wp                <= r_wp + 1'b1;
         end
         if (pop && !empty) r_rp <= r_rp + 1'b1;
      end
   end

   assign dout  = r_mem[r_rp[AW-1:0]];
   assign empty = (r_wp == r_rp);
   assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);

endmodule

// File: rtl/rv32i_instr_assembler.sv
// Encodes RV32I field requests into words, queues them, streams them to imem at consecutive addresses.
// Latency: request accepted at cycle N appears on wr_valid/wr_data at N+1 when the queue was empty.
// Backpressure: req_ready drops only when the word queue is full; wr_ready stalls hold addr/data stable.
module rv32i_instr_assembler
   import rv32i_pkg::*;
#(
   parameter int             DEPTH     = 4,
   parameter int             IMW       = 32,
   parameter logic [IMW-1:0] BASE_ADDR = '0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clear,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [6:0]     req_type,
   input  logic [3:0]     req_op,
   input  logic [ADW-1:0] req_rd,
   input  logic [ADW-1:0] req_rs1,
   input  logic [ADW-1:0] req_rs2,
   input  logic [12:0]    req_imm,
   output logic           wr_valid,
   input  logic           wr_ready,
   output logic [IMW-1:0] wr_addr,
   output logic [DPW-1:0] wr_data,
   output logic           err_illegal,
   output logic [7:0]     err_cnt,
   output logic [15:0]    wr_cnt
);

   enc_t           w_enc;
   logic           w_full;
   logic           w_empty;
   logic           w_acc;
   logic           w_push;
   logic           w_pop;
   logic           w_bad;
   logic [DPW-1:0] w_head;

   logic [IMW-1:0] r_addr;
   logic           r_err_ill;
   logic [7:0]     r_err_cnt;
   logic [15:0]    r_wr_cnt;

   assign w_enc     = encode_instr(req_type, req_op, req_rd, req_rs1, req_rs2, req_imm);
   // Held low while reset is asserted so no request is taken during reset.
   assign req_ready = !w_full && !rst;
   assign w_acc     = req_valid && req_ready;
   // clear discards whatever handshake happens in its cycle.
   assign w_push    = w_acc && !w_enc.illegal && !clear;
   assign w_bad     = w_acc &&  w_enc.illegal && !clear;
   assign w_pop     = !w_empty && wr_ready && !clear;

   rv32i_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (DPW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_enc.word),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   // Write address and written-word count advance once per completed memory write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr   <= BASE_ADDR;
         r_wr_cnt <= '0;
      end else if (clear) begin
         r_addr   <= BASE_ADDR;
         r_wr_cnt <= '0;
      end else if (w_pop) begin
         r_addr   <= r_addr + IMW'(4);
         r_wr_cnt <= r_wr_cnt + 16'd1;
      end
   end

   // Illegal-request pulse and saturating count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_ill <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err_ill <= w_bad;
         if (clear)
            r_err_cnt <= '0;
         else if (w_bad && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign wr_valid    = !w_empty;
   assign wr_data     = w_head;
   assign wr_addr     = r_addr;
   assign err_illegal = r_err_ill;
   assign err_cnt     = r_err_cnt;
   assign wr_cnt      = r_wr_cnt;

endmodule

// File: tb/tb_rv32i_instr_assembler.sv
// Directed bench: stimulus pushes expected {addr,word} into a scoreboard, a monitor pops on each write.
// Latency: checks the N+1 word appearance and the reset/clear values.
// Backpressure: stalls wr_ready to fill the queue and verifies hold-stable outputs.
module tb_rv32i_instr_assembler;
   import rv32i_pkg::*;

   logic        clk;
   logic        rst;
   logic        clear;
   logic        req_valid;
   logic        req_ready;
   logic [6:0]  req_type;
   logic [3:0]  req_op;
   logic [4:0]  req_rd;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [12:0] req_imm;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        err_illegal;
   logic [7:0]  err_cnt;
   logic [15:0] wr_cnt;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          err_seen = 0;
   logic [63:0] sb_q[$];
   logic [31:0] exp_addr = 32'h0;

   rv32i_instr_assembler #(
      .DEPTH     (4),
      .IMW       (32),
      .BASE_ADDR (32'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_type    (req_type),
      .req_op      (req_op),
      .req_rd      (req_rd),
      .req_rs1     (req_rs1),
      .req_rs2     (req_rs2),
      .req_imm     (req_imm),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .err_illegal (err_illegal),
      .err_cnt     (err_cnt),
      .wr_cnt      (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Monitor: scoreboard pops, stall stability, err pulse counting.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr;
   logic [31:0] prev_data;
   logic [63:0] ent;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (err_illegal) err_seen++;
         if (prev_stall && wr_valid) begin
            chk("stall_addr_stable", wr_addr, prev_addr);
            chk("stall_data_stable", wr_data, prev_data);
         end
         if (wr_valid && wr_ready) begin
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected", wr_addr, wr_data);
            end else begin
               ent = sb_q.pop_front();
               chk("wr_addr", wr_addr, ent[63:32]);
               chk("wr_data", wr_data, ent[31:0]);
            end
         end
         prev_stall = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
      end
   end

   task automatic set_req(input logic [6:0] t, input logic [3:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
      req_type  = t;
      req_op    = op;
      req_rd    = rd;
      req_rs1   = rs1;
      req_rs2   = rs2;
      req_imm   = imm;
      req_valid = 1'b1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic drive_req(input logic [6:0] t, input logic [3:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                            input logic legal, input logic [31:0] exp_w);
      logic acc;
      bit   done;
      done = 0;
      set_req(t, op, rd, rs1, rs2, imm);
      for (int i = 0; i < 64 && !done; i++) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         if (acc) begin
            done = 1;
            if (legal) begin
               sb_q.push_back({exp_addr, exp_w});
               exp_addr += 32'd4;
            end
         end
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL req_timeout: got no acceptance, required acceptance within 64 cycles");
      end
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 64 && sb_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_pending", sb_q.size(), 0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      sb_q.delete();
      exp_addr = 32'h0;
   endtask

   int e0;

   initial begin
      rst = 1'b1; clear = 1'b0; req_valid = 1'b0; wr_ready = 1'b1;
      req_type = '0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_wr_valid", wr_valid, 0);
      chk("rst_wr_addr", wr_addr, 32'h0);
      chk("rst_wr_data", wr_data, 32'h0);
      chk("rst_err", err_illegal, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_wr_cnt", wr_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", req_ready, 1);
      @(posedge clk); #1;

      // 1: R ADD, one-cycle latency
      drive_req(R_TYPE, ADD_OP, 5'd1, 5'd2, 5'd3, 13'd0, 1, 32'h003100B3);
      @(negedge clk);
      chk("t1_latency_valid", wr_valid, 1);
      @(negedge clk);
      chk("t1_wr_cnt", wr_cnt, 1);
      chk("t1_empty_after", wr_valid, 0);
      @(posedge clk); #1;

      // 2: back-to-back SUB then SRAI
      drive_req(R_TYPE, SUB_OP, 5'd5, 5'd6, 5'd7, 13'd0, 1, 32'h407302B3);
      drive_req(I_TYPE_ALU, SRA_OP, 5'd1, 5'd1, 5'd0, 13'd3, 1, 32'h4030D093);
      wait_drain();
      chk("t2_wr_cnt", wr_cnt, 3);

      // 3: SW, BEQ negative offset, LW, ADDI -1
      drive_req(S_TYPE, ADD_OP, 5'd0, 5'd0, 5'd2, 13'd8, 1, 32'h00202423);
      drive_req(B_TYPE, BEQ_OP, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1, 32'hFE208EE3);
      drive_req(I_TYPE_LOAD, XOR_OP, 5'd3, 5'd4, 5'd0, 13'h010, 1, 32'h01022183);
      drive_req(I_TYPE_ALU, ADD_OP, 5'd1, 5'd0, 5'd0, 13'h0FFF, 1, 32'hFFF00093);
      wait_drain();
      chk("t3_wr_cnt", wr_cnt, 7);

      // 4: backpressure, queue fills at four
      do_clear();
      wr_ready = 1'b0;
      drive_req(R_TYPE, ADD_OP, 5'd1, 5'd0, 5'd0, 13'd0, 1, 32'h000000B3);
      drive_req(R_TYPE, ADD_OP, 5'd2, 5'd0, 5'd0, 13'd0, 1, 32'h00000133);
      drive_req(R_TYPE, ADD_OP, 5'd3, 5'd0, 5'd0, 13'd0, 1, 32'h000001B3);
      drive_req(R_TYPE, ADD_OP, 5'd4, 5'd0, 5'd0, 13'd0, 1, 32'h00000233);
      set_req(R_TYPE, ADD_OP, 5'd5, 5'd0, 5'd0, 13'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_full_not_ready", req_ready, 0);
         chk("t4_stall_head", wr_data, 32'h000000B3);
      end
      @(posedge clk); #1;
      wr_ready = 1'b1;
      drive_req(R_TYPE, ADD_OP, 5'd5, 5'd0, 5'd0, 13'd0, 1, 32'h000002B3);
      wait_drain();
      chk("t4_addr_end", wr_addr, 32'h14);
      chk("t4_wr_cnt", wr_cnt, 5);

      // 5: illegal requests are accepted, dropped and counted
      do_clear();
      e0 = err_seen;
      drive_req(I_TYPE_ALU, SUB_OP, 5'd1, 5'd2, 5'd0, 13'd0, 0, 32'h0);
      drive_req(B_TYPE, BEQ_OP, 5'd0, 5'd1, 5'd2, 13'h3, 0, 32'h0);
      @(posedge clk); #1;
      chk("t5_err_pulses", err_seen - e0, 2);
      chk("t5_err_cnt", err_cnt, 2);
      chk("t5_no_write", wr_valid, 0);
      drive_req(R_TYPE, 4'd9, 5'd1, 5'd2, 5'd3, 13'd0, 0, 32'h0);
      drive_req(I_TYPE_ALU, BEQ_OP, 5'd1, 5'd2, 5'd0, 13'd0, 0, 32'h0);
      drive_req(B_TYPE, ADD_OP, 5'd0, 5'd1, 5'd2, 13'd4, 0, 32'h0);
      @(posedge clk); #1;
      chk("t5_err_cnt5", err_cnt, 5);
      chk("t5_no_write2", wr_valid, 0);
      // saturation at 255
      for (int i = 0; i < 256; i++)
         drive_req(7'h7F, ADD_OP, 5'd0, 5'd0, 5'd0, 13'd0, 0, 32'h0);
      @(posedge clk); #1;
      chk("t5_err_sat", err_cnt, 255);

      // 6: clear with words queued and a request in flight
      do_clear();
      chk("t6_clear_err_cnt", err_cnt, 0);
      wr_ready = 1'b0;
      drive_req(R_TYPE, ADD_OP, 5'd1, 5'd0, 5'd0, 13'd0, 1, 32'h000000B3);
      drive_req(R_TYPE, ADD_OP, 5'd2, 5'd0, 5'd0, 13'd0, 1, 32'h00000133);
      drive_req(R_TYPE, ADD_OP, 5'd3, 5'd0, 5'd0, 13'd0, 1, 32'h000001B3);
      set_req(R_TYPE, ADD_OP, 5'd4, 5'd0, 5'd0, 13'd0);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; req_valid = 1'b0;
      sb_q.delete(); exp_addr = 32'h0;
      @(negedge clk);
      chk("t6_empty", wr_valid, 0);
      chk("t6_addr", wr_addr, 32'h0);
      chk("t6_wr_cnt", wr_cnt, 0);
      chk("t6_ready", req_ready, 1);
      @(posedge clk); #1;
      wr_ready = 1'b1;
      // clear with an illegal request: no pulse, no count
      e0 = err_seen;
      set_req(7'h7F, ADD_OP, 5'd0, 5'd0, 5'd0, 13'd0);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; req_valid = 1'b0;
      @(posedge clk); #1;
      chk("t6_clear_no_pulse", err_seen - e0, 0);
      chk("t6_clear_no_cnt", err_cnt, 0);

      // async reset mid-burst
      drive_req(R_TYPE, ADD_OP, 5'd1, 5'd0, 5'd0, 13'd0, 1, 32'h000000B3);
      drive_req(7'h7F, ADD_OP, 5'd0, 5'd0, 5'd0, 13'd0, 0, 32'h0);
      drive_req(R_TYPE, ADD_OP, 5'd2, 5'd0, 5'd0, 13'd0, 1, 32'h00000133);
      set_req(R_TYPE, ADD_OP, 5'd3, 5'd0, 5'd0, 13'd0);
      #1;
      rst = 1'b1;
      sb_q.delete(); exp_addr = 32'h0;
      #1;
      chk("arst_wr_valid", wr_valid, 0);
      chk("arst_req_ready", req_ready, 0);
      chk("arst_wr_addr", wr_addr, 32'h0);
      chk("arst_wr_data", wr_data, 32'h0);
      chk("arst_err", err_illegal, 0);
      chk("arst_err_cnt", err_cnt, 0);
      chk("arst_wr_cnt", wr_cnt, 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      drive_req(R_TYPE, ADD_OP, 5'd1, 5'd2, 5'd3, 13'd0, 1, 32'h003100B3);
      wait_drain();
      @(posedge clk); #1;
      chk("post_rst_addr", wr_addr, 32'h4);
      chk("post_rst_wr_cnt", wr_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rv32i_instr_assembler.md
Name: rv32i_instr_assembler

Overview:
Converts field-level instruction requests (type, ALU op, registers, immediate) into 32-bit RV32I machine words. Buffers the encoded words in a small FIFO. Streams them into instruction memory at consecutive word addresses. It is the writer/encoder counterpart to the core's fetch/decode path, and is used for program loading and directed test injection.

Parameters:
DEPTH, 4, encoded-word FIFO entries (power of two, >=2)
IMW, 32, instruction-memory byte-address width
BASE_ADDR, 0, first write address after reset/clear (word aligned)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush: empty FIFO, address := BASE_ADDR, err_cnt := 0
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_type  in  7  instr_type_t opcode
req_op  in  4  alu_op_t
req_rd  in  ADW  destination register
req_rs1  in  ADW  source 1
req_rs2  in  ADW  source 2
req_imm  in  13  immediate (I/S use [11:0]; B uses [12:1], [0] must be 0; shifts use [4:0])
wr_valid  out  1  memory write valid
wr_ready  in  1  memory accepts write
wr_addr  out  IMW  byte address
wr_data  out  DPW  encoded instruction
err_illegal  out  1  one-cycle pulse: accepted request was illegal, dropped
err_cnt  out  8  saturating count of illegal requests
wr_cnt  out  16  words written since reset/clear (wraps)

Behaviour:
- Reset: req_ready=0 during reset, then 1. wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, err_illegal=0, err_cnt=0, wr_cnt=0. FIFO empty.
- req_ready = !full. There is no same-cycle bypass when full.
- Encoding, registered into the FIFO tail on acceptance:
  - R_TYPE: funct7|rs2|rs1|funct3|rd|0110011. ADD 000/0000000, SUB 000/0100000, AND 111, OR 110, XOR 100, SLL 001, SRL 101/0000000, SRA 101/0100000.
  - I_TYPE_ALU: imm[11:0]|rs1|funct3|rd. ADD, AND, OR, XOR use imm[11:0]. SLL, SRL, SRA use {funct7, imm[4:0]}. SUB is illegal.
  - I_TYPE_LOAD: LW, funct3 010. req_op is ignored.
  - S_TYPE: SW, imm[11:5]|rs2|rs1|010|imm[4:0].
  - B_TYPE: op must be BEQ_OP, funct3 000, imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11].
- Illegal requests:
  - Covers: undefined opcode, BEQ_OP outside B_TYPE, non-BEQ in B_TYPE, SUB in I_TYPE_ALU, B_TYPE with imm[0]=1, op value >8 in R/I_ALU.
  - An illegal request is still accepted (handshake completes) and is not pushed.
  - err_illegal pulses in the cycle after acceptance.
  - err_cnt increments and saturates at 255.
- Latency: request accepted at cycle N -> wr_valid=1 with that word at N+1 (FIFO was empty, wr_ready irrelevant).
- Write side:
  - wr_valid = !empty. wr_data = FIFO head.
  - On wr_valid && wr_ready: pop, wr_addr += 4 (wraps modulo 2^IMW), wr_cnt++.
  - wr_addr/wr_data hold stable while wr_valid && !wr_ready.
- Simultaneous push and pop: allowed in any non-full state. Occupancy is unchanged. Order is preserved.
- clear has priority over push/pop in the same cycle. Any in-flight request or write in that cycle is discarded, and no err_illegal is raised for it.
- Reset mid-stream: all state returns to reset values immediately (asynchronous). Partially written programs are not resumed.

Decomposition:
- Add to rv32i_pkg: funct3/funct7 localparams per alu_op_t; LW/SW funct3 constants.
- Add to rv32i_pkg: a pure function encode_instr(type, op, rd, rs1, rs2, imm) returning {illegal, word}, shared with the verification model.
- One sub-module: rv32i_sync_fifo (DEPTH, width DPW), with push/pop/full/empty/clear.

Test Plan:
1. R_TYPE ADD rd=1 rs1=2 rs2=3, wr_ready=1 -> wr_data=0x003100B3 at wr_addr=0x0, one cycle after acceptance; wr_cnt=1.
2. Back-to-back: R_TYPE SUB rd=5 rs1=6 rs2=7 then I_TYPE_ALU SRA rd=1 rs1=1 imm=3 -> 0x407302B3 @0x0, then 0x4030D093 @0x4.
3. S_TYPE rs1=0 rs2=2 imm=8 -> 0x00202423. B_TYPE BEQ rs1=1 rs2=2 imm=0x1FFC (-4) -> 0xFE208EE3.
4. Backpressure: wr_ready=0, 5 requests offered -> 4 accepted, req_ready=0 after the 4th. Release wr_ready -> words emitted in order at 0x0,0x4,0x8,0xC, then the 5th at 0x10. wr_addr/wr_data stable while stalled.
5. Illegal: I_TYPE_ALU SUB, then B_TYPE imm=0x3 -> both accepted, err_illegal pulses twice, err_cnt=2, wr_valid stays 0.
6. clear asserted with 3 words queued and a request valid -> FIFO empty, wr_addr=BASE_ADDR, wr_cnt=0, request dropped. Async rst mid-burst -> all outputs at reset values within the same cycle.
